// File: rtl/rat.sv
// Register alias table with a FIFO free list of physical tags.
// Sources are looked up combinationally; a granted rename updates the map at the clock edge.
module rat #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_TAGS = 64,
  parameter int TAG_W     = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         out_of_tags,
  input  logic                         alloc_req,
  input  logic [$clog2(ARCH_REGS)-1:0] alloc_arch,
  output logic                         alloc_grant,
  output logic [TAG_W-1:0]             alloc_tag,
  output logic [TAG_W-1:0]             alloc_old_tag,
  input  logic [$clog2(ARCH_REGS)-1:0] rs1_arch,
  output logic [TAG_W-1:0]             rs1_tag,
  input  logic [$clog2(ARCH_REGS)-1:0] rs2_arch,
  output logic [TAG_W-1:0]             rs2_tag,
  input  logic                         free_req,
  input  logic [TAG_W-1:0]             free_tag,
  output logic [TAG_W-1:0]             free_count
);

  localparam int PTR_W = $clog2(PHYS_TAGS);
  localparam int CNT_W = $clog2(PHYS_TAGS + 1);

  logic [TAG_W-1:0] map_q [ARCH_REGS];
  logic [TAG_W-1:0] fl_q  [PHYS_TAGS];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_free;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(PHYS_TAGS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_of_tags   = (count_q == '0);
  assign alloc_grant   = alloc_req && !out_of_tags;
  assign do_free       = free_req && (count_q < CNT_W'(PHYS_TAGS));
  assign alloc_tag     = fl_q[head_q];
  assign alloc_old_tag = map_q[alloc_arch];
  assign rs1_tag       = map_q[rs1_arch];
  assign rs2_tag       = map_q[rs2_arch];
  assign free_count    = TAG_W'(count_q);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (alloc_grant) head_d = ptr_inc(head_q);
    if (do_free)     tail_d = ptr_inc(tail_q);
    case ({alloc_grant, do_free})
      2'b10:   count_d = count_q - 1'b1;
      2'b01:   count_d = count_q + 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Reset also rebuilds the map and free list: a mid-run reset must restore identity.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= TAG_W'(i);
      for (int i = 0; i < PHYS_TAGS; i++)
        fl_q[i] <= (i < PHYS_TAGS - ARCH_REGS) ? TAG_W'(ARCH_REGS + i) : '0;
      head_q  <= '0;
      tail_q  <= PTR_W'(PHYS_TAGS - ARCH_REGS);
      count_q <= CNT_W'(PHYS_TAGS - ARCH_REGS);
    end else begin
      if (alloc_grant) map_q[alloc_arch] <= fl_q[head_q];
      if (do_free)     fl_q[tail_q]      <= free_tag;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rat.sv
// Scoreboard bench for rat: a queue-based reference model predicts every cycle's outputs.
module tb_rat;
  localparam int AR = 32;
  localparam int PT = 64;
  localparam int TW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, out_of_tags, alloc_req, alloc_grant, free_req;
  logic [4:0]    alloc_arch, rs1_arch, rs2_arch;
  logic [TW-1:0] alloc_tag, alloc_old_tag, rs1_tag, rs2_tag, free_tag, free_count;

  rat #(.ARCH_REGS(AR), .PHYS_TAGS(PT), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .out_of_tags(out_of_tags),
    .alloc_req(alloc_req), .alloc_arch(alloc_arch), .alloc_grant(alloc_grant),
    .alloc_tag(alloc_tag), .alloc_old_tag(alloc_old_tag),
    .rs1_arch(rs1_arch), .rs1_tag(rs1_tag), .rs2_arch(rs2_arch), .rs2_tag(rs2_tag),
    .free_req(free_req), .free_tag(free_tag), .free_count(free_count)
  );

  typedef struct {
    bit chk;
    bit oot;
    bit grant;
    int tag;
    int old;
    int r1;
    int r2;
    int fc;
  } exp_t;

  exp_t exp_q[$];
  int   m_map[AR];
  int   m_fl[$];
  int   pool[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < AR; i++) m_map[i] = i;
    m_fl.delete();
    for (int t = AR; t < PT; t++) m_fl.push_back(t);
    pool.delete();
  endtask

  function automatic void take(input int tag);
    for (int i = 0; i < pool.size(); i++)
      if (pool[i] == tag) begin
        pool.delete(i);
        return;
      end
  endfunction

  task automatic drive(input bit rq, input int arch, input bit fq, input int ftag,
                       input int r1, input int r2, input bit rst, input bit ck);
    exp_t e;
    bit   fa;
    @(posedge clk);
    #1;
    reset = rst; alloc_req = rq; alloc_arch = 5'(arch);
    free_req = fq; free_tag = TW'(ftag);
    rs1_arch = 5'(r1); rs2_arch = 5'(r2);
    e.chk   = ck;
    e.oot   = (m_fl.size() == 0);
    e.grant = rq && (m_fl.size() != 0);
    e.tag   = (m_fl.size() != 0) ? m_fl[0] : 0;
    e.old   = m_map[arch];
    e.r1    = m_map[r1];
    e.r2    = m_map[r2];
    e.fc    = m_fl.size();
    exp_q.push_back(e);
    if (rst) model_reset();
    else begin
      fa = fq && (m_fl.size() < PT);
      if (e.grant) begin
        pool.push_back(m_map[arch]);
        m_map[arch] = m_fl.pop_front();
      end
      if (fa) m_fl.push_back(ftag);
    end
  endtask

  task automatic idle(input int r1, input int r2);
    drive(0, 0, 0, 0, r1, r2, 0, 1);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response to score.
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        check("out_of_tags", int'(out_of_tags), int'(e.oot));
        check("free_count", int'(free_count), e.fc);
        check("alloc_grant", int'(alloc_grant), int'(e.grant));
        check("rs1_tag", int'(rs1_tag), e.r1);
        check("rs2_tag", int'(rs2_tag), e.r2);
        check("alloc_old_tag", int'(alloc_old_tag), e.old);
        if (e.grant) check("alloc_tag", int'(alloc_tag), e.tag);
      end
    end
  end

  initial begin
    int  tag, idx;
    bit  fq;
    reset = 1'b1; alloc_req = 1'b0; alloc_arch = '0; free_req = 1'b0;
    free_tag = '0; rs1_arch = '0; rs2_arch = '0;
    model_reset();

    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(5, 31);
    drive(1, 3, 0, 0, 3, 3, 0, 1);
    idle(3, 0);

    drive(0, 0, 0, 0, 0, 0, 1, 1);
    for (int r = 0; r < AR; r++) drive(1, r, 0, 0, r, (r + 1) % AR, 0, 1);
    drive(1, 5, 0, 0, 5, 6, 0, 1);
    idle(5, 6);

    take(7);
    drive(1, 2, 1, 7, 2, 7, 0, 1);
    drive(1, 2, 0, 0, 2, 9, 0, 1);
    idle(2, 9);

    take(4);
    for (int i = 0; i < 20; i++) drive(0, 0, 1, pool.pop_front(), i, 31 - i, 0, 1);
    drive(1, 10, 1, 4, 10, 11, 0, 1);
    for (int i = 0; i < 21; i++) drive(1, (i * 7) % AR, 0, 0, 10, i, 0, 1);

    for (int i = 0; i < 700; i++) begin
      fq = (pool.size() > 0) && (((i / 100) % 2 == 0) ? ($urandom_range(0, 9) < 7)
                                                       : ($urandom_range(0, 9) < 2));
      tag = 0;
      if (fq) begin
        idx = $urandom_range(0, pool.size() - 1);
        tag = pool[idx];
        pool.delete(idx);
      end
      drive($urandom_range(0, 2) != 0, $urandom_range(0, AR - 1), fq, tag,
            $urandom_range(0, AR - 1), $urandom_range(0, AR - 1),
            $urandom_range(0, 149) == 0, 1);
    end

    for (int i = 0; i < 6; i++) drive(1, i + 1, 0, 0, 0, 0, 0, 1);
    drive(1, 9, 0, 0, 1, 2, 1, 1);
    for (int i = 0; i < 4; i++) idle(i * 8 + 1, 9);

    @(posedge clk);
    @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rat.md
Name: rat

Overview:
Register alias table and physical-tag allocator for the out-of-order microcode back end. It maps 32 architectural registers to physical tags and keeps a FIFO free list of unused tags. It sits after the decode pipeline register: decode-stage source fields are looked up here, and each destination register is renamed here. It signals when no tag is available, so rename and dispatch can stall.

Parameters:
ARCH_REGS, 32, number of architectural registers (index width 5).
PHYS_TAGS, 64, number of physical tags (must be > ARCH_REGS, <= 512).
TAG_W, 9, physical tag width.

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
out_of_tags  output  1  high when the free list is empty.
alloc_req  input  1  rename request for a destination register this cycle.
alloc_arch  input  5  architectural destination register to rename.
alloc_grant  output  1  alloc_req && !out_of_tags (combinational).
alloc_tag  output  TAG_W  tag at free-list head; valid when alloc_grant.
alloc_old_tag  output  TAG_W  current mapping of alloc_arch before the update (for later release at commit).
rs1_arch  input  5  source 1 architectural index.
rs1_tag  output  TAG_W  current mapping of rs1_arch (combinational).
rs2_arch  input  5  source 2 architectural index.
rs2_tag  output  TAG_W  current mapping of rs2_arch (combinational).
free_req  input  1  return a tag to the free list.
free_tag  input  TAG_W  tag being returned.
free_count  output  TAG_W  number of tags currently in the free list.

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk. The first three ports are in the fixed order clk, reset, out_of_tags, so the block can be instantiated positionally with only these three connected.
- State:
  - map[0..ARCH_REGS-1] of TAG_W bits.
  - Circular free-list array of PHYS_TAGS entries, with head pointer, tail pointer and count.
- Reset, on a clock edge with reset high, overriding any request in that cycle:
  - map[i] = i.
  - Free-list entries 0..PHYS_TAGS-ARCH_REGS-1 hold tags ARCH_REGS..PHYS_TAGS-1 in ascending order.
  - head = 0, tail = PHYS_TAGS-ARCH_REGS, count = PHYS_TAGS-ARCH_REGS.
  - Resulting outputs: out_of_tags = 0, free_count = 32 with default parameters.
- out_of_tags = (count == 0), driven from registered state only.
- Lookups are purely combinational from the current map and have zero latency.
  - In a cycle where a grant renames the same register, they return the pre-update value (sources are read before the destination is renamed).
- Allocation, when alloc_grant = 1:
  - alloc_tag = freelist[head] and alloc_old_tag = map[alloc_arch], both combinational in the same cycle.
  - At the clock edge: map[alloc_arch] <= alloc_tag, head <= head+1 mod PHYS_TAGS, count <= count-1.
- alloc_req while out_of_tags:
  - alloc_grant = 0; map, head and count are unchanged.
  - alloc_tag and alloc_old_tag still show freelist[head] and map[alloc_arch] but are don't-care to consumers.
- Free, when free_req = 1 and count < PHYS_TAGS:
  - freelist[tail] <= free_tag, tail <= tail+1 mod PHYS_TAGS, count <= count+1.
  - free_req with count == PHYS_TAGS is ignored.
  - free_tag is not checked for duplicates; the caller guarantees uniqueness.
- Simultaneous grant and free in one cycle:
  - Both take effect and count is unchanged.
  - A free in a cycle where out_of_tags = 1 does not enable a grant in that same cycle; the returned tag is allocatable from the next cycle.
- Architectural register 0 is renamed like any other register.
- Pointers wrap modulo PHYS_TAGS. FIFO order is strict, so tags are reissued in the order they were freed.
- Reset asserted mid-operation discards all mappings and returns the table to the identity mapping.

Test Plan:
- Reset, then idle → rs1_arch = 5 gives rs1_tag = 5; rs2_arch = 31 gives rs2_tag = 31; free_count = 32; out_of_tags = 0.
- alloc_req with alloc_arch = 3 for one cycle → same cycle: alloc_grant = 1, alloc_tag = 32, alloc_old_tag = 3, rs1_arch = 3 gives 3. Next cycle: rs1_arch = 3 gives 32, free_count = 31.
- 32 consecutive allocations to registers 0..31 → tags 32..63 issued in order. out_of_tags = 1 afterwards. A 33rd alloc_req gives alloc_grant = 0 and the map is unchanged.
- While out_of_tags, pulse free_req with free_tag = 7 → alloc_grant stays 0 that cycle. Next cycle: out_of_tags = 0, and an alloc gives alloc_tag = 7.
- Simultaneous alloc (register 10) and free (tag 4) with free_count = 20 → free_count stays 20, map[10] = the head tag, and tag 4 is queued at the tail.
- After several renames, assert reset for one cycle together with alloc_req → identity map restored, free_count = 32, and the request is not applied.
